// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: round-robin arbiter giving an I-cache (port 0) and a D-cache (port 1) one shared memory port
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   pN_req/we/addr/wdata              request from port N, held until pN_ready or pN_err
//   pN_ready/err                      one-cycle completion / timeout-abort pulse to port N
//   pN_rdata                          last read data returned to port N
//   mem_request/write_enable/address/write_data, mem_ready, mem_response_data   memory side
//   arb_state                         current FSM state (IDLE=0, ISSUE=1, WAIT_DATA=2, RESP=3)
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ready,
    output logic                  p0_err,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ready,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_request,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_response_data,
    output logic [1:0]            arb_state
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

    state_t                r_state, w_next;
    logic                  r_owner, r_we, r_last_grant, r_abort;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_p0_rdata, r_p1_rdata;
    logic [CW-1:0]         r_wait_cnt;
    logic                  w_any, w_grant, w_timeout;

    assign w_any     = p0_req | p1_req;
    // on a tie the port that did not win last time goes next
    assign w_grant   = (p0_req & p1_req) ? ~r_last_grant : p1_req;
    // this stalled cycle is the one that brings the wait count up to the limit
    assign w_timeout = !mem_ready && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_any ? ISSUE : IDLE;
            ISSUE:     w_next = mem_ready ? (r_we ? RESP : WAIT_DATA) : (w_timeout ? RESP : ISSUE);
            WAIT_DATA: w_next = RESP;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
            r_abort      <= 1'b0;
            r_wait_cnt   <= '0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_owner    <= w_grant;
                r_we       <= w_grant ? p1_we : p0_we;
                r_addr     <= w_grant ? p1_addr : p0_addr;
                r_wdata    <= w_grant ? p1_wdata : p0_wdata;
                r_wait_cnt <= '0;
                r_abort    <= 1'b0;
            end
            if (r_state == ISSUE) begin
                if (!mem_ready)
                    r_wait_cnt <= r_wait_cnt + CW'(1);
                r_abort <= w_timeout;
            end
            if (r_state == WAIT_DATA) begin
                if (r_owner)
                    r_p1_rdata <= mem_response_data;
                else
                    r_p0_rdata <= mem_response_data;
            end
            if (r_state == RESP)
                r_last_grant <= r_owner;
        end
    end

    // address/data come straight from the latch, so they hold their last value outside ISSUE
    assign mem_request      = (r_state == ISSUE);
    assign mem_write_enable = (r_state == ISSUE) && r_we;
    assign mem_address      = r_addr;
    assign mem_write_data   = r_wdata;
    assign p0_ready         = (r_state == RESP) && !r_owner && !r_abort;
    assign p0_err           = (r_state == RESP) && !r_owner && r_abort;
    assign p1_ready         = (r_state == RESP) && r_owner && !r_abort;
    assign p1_err           = (r_state == RESP) && r_owner && r_abort;
    assign p0_rdata         = r_p0_rdata;
    assign p1_rdata         = r_p1_rdata;
    assign arb_state        = r_state;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed scenarios for l1_mem_arbiter against a small memory model
module tb_l1_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ready, p0_err, p1_ready, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_request, mem_write_enable, mem_ready;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_response_data = '0;
    logic [1:0]  arb_state;
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad = 0;
    int          cyc, who, mreq;
    bit          err, excl;
    logic        we;
    logic [31:0] a, d;

    always #5 clk = ~clk;

    l1_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_request(mem_request), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_ready(mem_ready), .mem_response_data(mem_response_data),
        .arb_state(arb_state)
    );

    // memory model: data for an accepted read is presented the cycle after acceptance
    always @(posedge clk) begin
        if (mem_request && mem_ready) begin
            if (mem_write_enable)
                mem[mem_address] = mem_write_data;
            else
                mem_response_data <= mem.exists(mem_address) ? mem[mem_address] : 32'hDEAD0000;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        p0_req = 0; p1_req = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // waits for the next ready/err pulse on either port, recording what memory saw meanwhile
    task automatic wait_any(output int c, output int w, output bit e, output int mr,
                            output logic mwe, output logic [31:0] ma, output logic [31:0] md, output bit x);
        c = -1; w = -1; e = 0; mr = 0; mwe = 0; ma = 0; md = 0; x = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (mem_request) begin
                mr++; mwe = mem_write_enable; ma = mem_address; md = mem_write_data;
            end
            if (((p0_ready | p0_err) && (p1_ready | p1_err)) || (p0_ready && p0_err) || (p1_ready && p1_err))
                x = 1;
            if (p0_ready | p0_err | p1_ready | p1_err) begin
                c = i; w = (p1_ready | p1_err) ? 1 : 0; e = p0_err | p1_err;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL reset_state got %0d want 0", arb_state); end
        total++; if ({mem_request, mem_write_enable, p0_ready, p0_err, p1_ready, p1_err} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got %b want 000000", {mem_request, mem_write_enable, p0_ready, p0_err, p1_ready, p1_err}); end
        total++; if ({p0_rdata, p1_rdata, mem_address, mem_write_data} !== 128'b0) begin bad++; $display("FAIL reset_data got %h want 0", {p0_rdata, p1_rdata, mem_address, mem_write_data}); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        mem_ready = 1;
        p1_req = 1; p1_we = 0; p1_addr = 32'h200; p1_wdata = 0;
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p1_req = 0;
        total++; if (cyc !== 3) begin bad++; $display("FAIL read_latency got %0d want 3", cyc); end
        total++; if (who !== 1 || err !== 0) begin bad++; $display("FAIL read_owner got port%0d err%0d want port1 err0", who, err); end
        total++; if (mreq !== 1) begin bad++; $display("FAIL read_memreq_cycles got %0d want 1", mreq); end
        total++; if (a !== 32'h200 || we !== 0) begin bad++; $display("FAIL read_issue got addr %h we %b want 200 0", a, we); end
        total++; if (p1_rdata !== 32'hAAAAAAAA) begin bad++; $display("FAIL read_p1_rdata got %h want aaaaaaaa", p1_rdata); end
        total++; if (p0_rdata !== 32'h0) begin bad++; $display("FAIL read_p0_rdata got %h want 0", p0_rdata); end
        total++; if (excl !== 0) begin bad++; $display("FAIL read_pulse_excl got %b want 0", excl); end
        tick();
        total++; if (arb_state !== 2'd0 || p1_ready !== 0) begin bad++; $display("FAIL read_return got state %0d ready %b want 0 0", arb_state, p1_ready); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        p0_req = 1; p0_we = 0; p0_addr = 32'h200; p0_wdata = 32'h12345678;
        p1_req = 1; p1_we = 1; p1_addr = 32'h20C; p1_wdata = 32'hBEEFDEAD;
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p0_req = 0;
        p0_addr = 32'h999; p0_we = 1;
        total++; if (who !== 0 || cyc !== 3) begin bad++; $display("FAIL tie_first got port%0d at %0d want port0 at 3", who, cyc); end
        total++; if (p0_rdata !== 32'hAAAAAAAA) begin bad++; $display("FAIL tie_p0_rdata got %h want aaaaaaaa", p0_rdata); end
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p1_req = 0;
        p1_wdata = 32'h0;
        total++; if (who !== 1 || cyc !== 3 || err !== 0) begin bad++; $display("FAIL tie_second got port%0d at %0d err%0d want port1 at 3 err0", who, cyc, err); end
        total++; if (we !== 1 || a !== 32'h20C || d !== 32'hBEEFDEAD) begin bad++; $display("FAIL tie_write_issue got we %b addr %h data %h want 1 20c beefdead", we, a, d); end
        total++; if (mem[32'h20C] !== 32'hBEEFDEAD) begin bad++; $display("FAIL tie_write_mem got %h want beefdead", mem[32'h20C]); end
        total++; if (p1_rdata !== 32'h0 || p0_rdata !== 32'hAAAAAAAA) begin bad++; $display("FAIL write_rdata got p0 %h p1 %h want aaaaaaaa 0", p0_rdata, p1_rdata); end
        tick();
    endtask

    task automatic test_fairness();
        p0_req = 1; p0_we = 0; p0_addr = 32'h200;
        p1_req = 1; p1_we = 0; p1_addr = 32'h3FF;
        for (int i = 0; i < 6; i++) begin
            wait_any(cyc, who, err, mreq, we, a, d, excl);
            total++; if (who !== (i % 2) || cyc !== (i == 0 ? 3 : 4)) begin bad++; $display("FAIL fair_grant%0d got port%0d at %0d want port%0d at %0d", i, who, cyc, i % 2, i == 0 ? 3 : 4); end
        end
        p0_req = 0; p1_req = 0;
        total++; if (p0_rdata !== 32'hAAAAAAAA || p1_rdata !== 32'h11111111) begin bad++; $display("FAIL fair_rdata got %h %h want aaaaaaaa 11111111", p0_rdata, p1_rdata); end
        tick();
    endtask

    task automatic test_timeout();
        mem_ready = 0;
        p0_req = 1; p0_we = 0; p0_addr = 32'h100;
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p0_req = 0;
        total++; if (mreq !== 16) begin bad++; $display("FAIL to_memreq_cycles got %0d want 16", mreq); end
        total++; if (cyc !== 17 || who !== 0 || err !== 1) begin bad++; $display("FAIL to_err got port%0d at %0d err%0d want port0 at 17 err1", who, cyc, err); end
        total++; if (p0_ready !== 0 || mem_request !== 0) begin bad++; $display("FAIL to_no_ready got ready %b req %b want 0 0", p0_ready, mem_request); end
        total++; if (p0_rdata !== 32'hAAAAAAAA) begin bad++; $display("FAIL to_rdata got %h want aaaaaaaa", p0_rdata); end
        tick();
        total++; if (arb_state !== 2'd0 || p0_err !== 0) begin bad++; $display("FAIL to_return got state %0d err %b want 0 0", arb_state, p0_err); end
        mem_ready = 1;
    endtask

    task automatic test_stall();
        apply_reset();
        mem_ready = 0;
        p1_req = 1; p1_we = 0; p1_addr = 32'h3FF;
        repeat (6) tick();
        total++; if (arb_state !== 2'd1 || mem_request !== 1) begin bad++; $display("FAIL stall_issue got state %0d req %b want 1 1", arb_state, mem_request); end
        mem_ready = 1;
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p1_req = 0;
        total++; if (cyc + 6 !== 8 || who !== 1 || err !== 0) begin bad++; $display("FAIL stall_latency got port%0d at %0d err%0d want port1 at 8 err0", who, cyc + 6, err); end
        total++; if (p1_rdata !== 32'h11111111) begin bad++; $display("FAIL stall_rdata got %h want 11111111", p1_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_ready = 1;
        p0_req = 1; p0_we = 0; p0_addr = 32'h200;
        tick();
        tick();
        total++; if (arb_state !== 2'd2) begin bad++; $display("FAIL mid_wait_state got %0d want 2", arb_state); end
        reset_n = 0;
        #1;
        total++; if (arb_state !== 2'd0 || {mem_request, p0_ready, p0_err, p1_ready, p1_err} !== 5'b0) begin bad++; $display("FAIL mid_reset_ctrl got state %0d flags %b want 0 00000", arb_state, {mem_request, p0_ready, p0_err, p1_ready, p1_err}); end
        total++; if ({p0_rdata, p1_rdata, mem_address} !== 96'b0) begin bad++; $display("FAIL mid_reset_data got %h want 0", {p0_rdata, p1_rdata, mem_address}); end
        p1_req = 1; p1_we = 0; p1_addr = 32'h3FF;
        repeat (2) @(posedge clk);
        #1;
        total++; if (p0_ready !== 0 || mem_request !== 0) begin bad++; $display("FAIL mid_held got ready %b req %b want 0 0", p0_ready, mem_request); end
        reset_n = 1;
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p0_req = 0;
        total++; if (who !== 0 || cyc !== 3) begin bad++; $display("FAIL mid_tie got port%0d at %0d want port0 at 3", who, cyc); end
        wait_any(cyc, who, err, mreq, we, a, d, excl);
        p1_req = 0;
        total++; if (who !== 1 || excl !== 0) begin bad++; $display("FAIL mid_next got port%0d excl %b want port1 0", who, excl); end
        tick();
    endtask

    initial begin
        mem[32'h200] = 32'hAAAAAAAA;
        mem[32'h3FF] = 32'h11111111;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        mem_ready = 1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
